ringbuf_reader: RTL and testbench
=================================

# ringbuf_reader

Reads one event's samples out of the 12-bit DAQ ring buffer and streams them as framed 16-bit words to the downstream DAQ output FIFO. Each event is one header, then NSAMP×16 data words in channel-major order, then one trailer. It sits on the read port of the ring buffer, opposite the channel-FIFO-to-ring-buffer transfer logic. It is launched by the L1A match logic with a start address and a sample count.

## Interface
- ADDR_W, 11, ring buffer address width (depth 2^ADDR_W words)
- CLK  in  1  system clock, all logic rising-edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  one-cycle launch pulse; honoured only in IDLE
- START_ADDR  in  ADDR_W  ring buffer address of sample 0, channel 0
- NSAMP  in  5  samples per channel to read, 0..31
- RB_ADDR  out  ADDR_W  ring buffer read address
- RB_RDEN  out  1  ring buffer read enable; data appears on RB_DOUT the next cycle
- RB_DOUT  in  12  ring buffer read data
- DOUT_AF  in  1  downstream almost-full; asserted with ≥3 free entries remaining
- DOUT  out  16  output word
- DOUT_VLD  out  1  output word valid (write strobe)
- DOUT_LAST  out  1  marks the trailer word
- BUSY  out  1  event in progress
- DONE  out  1  one-cycle pulse with the trailer
- OVLP  out  1  sticky flag: START was seen while not IDLE; cleared only by RST

## Operation
- FSM states: IDLE, HDR, READ, DRAIN, TRL.
  - IDLE→HDR on START. START_ADDR and NSAMP are latched at that point.
  - HDR→READ after the header is emitted if NSAMP≠0; otherwise HDR→TRL.
  - READ→DRAIN after the last read is issued.
  - DRAIN→TRL once the 2-stage read pipeline is empty.
  - TRL→IDLE after the trailer is emitted.
- Header word: {4'hA, EVT_CNT[11:0]}.
- Data word: {chan[3:0], RB_DOUT}. chan is the channel index of the read that produced the word.
- Read order: sample s = 0..NSAMP-1, channel c = 0..15. Address = START_ADDR + 16·s + c, modulo 2^ADDR_W. The address wraps from all-ones to 0.
- Trailer word: {4'hF, T[11:0]}. T is defined under Configuration.
- EVT_CNT: 12-bit internal counter.
  - Increments when the trailer is emitted.
  - Wraps from 0xFFF to 0x000.
- Backpressure:
  - RB_RDEN = (state==READ) & ~DOUT_AF. The address and channel counters advance only on RB_RDEN.
  - HDR and TRL hold while DOUT_AF=1.
  - Reads already in flight are always delivered, which is why DOUT_AF carries a 3-entry margin.
- START while BUSY: ignored, and OVLP is set.
- Reset values: every output is 0, including RB_ADDR, DOUT, OVLP and BUSY. EVT_CNT=0, FSM=IDLE.
- RST mid-event: the event is aborted immediately, no trailer is emitted, and EVT_CNT returns to 0.

## Timing
- The START edge is cycle 0. N = 16·NSAMP. The following applies with DOUT_AF=0.
- Cycle 1: BUSY=1, header word on DOUT with DOUT_VLD=1.
- Cycles 2..N+1: RB_RDEN=1, with RB_ADDR = START_ADDR+k at cycle 2+k.
- Cycles 4..N+3: data words. DOUT_VLD is 0 in cycles 2–3.
- Data latency is 2 cycles from RB_RDEN to DOUT_VLD: 1 cycle for the RAM, 1 for the output register.
- Cycle N+4: trailer, with DOUT_LAST=1 and DONE=1.
- Cycle N+5: BUSY=0. The next START is accepted from cycle N+5 onward.
- NSAMP=0: header at cycle 1, trailer at cycle 2, BUSY=0 at cycle 3.
- Each DOUT_AF cycle during READ inserts exactly one bubble in the output stream, 2 cycles later. Data order is unchanged.

## Configuration
- Macro: RINGBUF_RD_CHKSUM_EN.
- Defined: T = bitwise XOR of all 12-bit samples in the event. T=0x000 when NSAMP=0.
- Undefined: T = N (the data word count, max 496 = 0x1F0). The checksum logic is not built.

## Test plan
- RST, then START with START_ADDR=0x010, NSAMP=1, RAM[a]=a: expect 0xA000 at cycle 1, then 0x0010…0xF01F at cycles 4..19. Trailer at cycle 20 is 0xF000 with the checksum macro defined, 0xF010 without. BUSY=0 at cycle 21.
- START_ADDR=0x7F8, NSAMP=1: RB_ADDR sequence is 0x7F8..0x7FF, then 0x000..0x007. All data words arrive in order.
- NSAMP=0 twice back-to-back: expect headers 0xA000 and 0xA001, trailers 0xF000 with DOUT_LAST and DONE, and no RB_RDEN.
- NSAMP=2 with DOUT_AF pulsed high for 3 cycles mid-READ: 32 data words arrive in correct order, with exactly 3 bubbles and no loss or duplication.
- START again at cycle 5 of an event: the second START is ignored, OVLP=1 and remains set after the event completes.
- RST asserted at cycle 10 of an NSAMP=4 event: all outputs are 0 immediately. The next event's header is 0xA000.

Source files
------------

// File: rtl/ringbuf_reader.sv
// ringbuf_reader: streams one event (header, NSAMP x 16 channel-major samples, trailer) from the ring buffer.
// Define RINGBUF_RD_CHKSUM_EN to replace the trailer's word count with the XOR of all event samples.
module ringbuf_reader #(
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [4:0]        NSAMP,
  output logic [ADDR_W-1:0] RB_ADDR,
  output logic              RB_RDEN,
  input  logic [11:0]       RB_DOUT,
  input  logic              DOUT_AF,
  output logic [15:0]       DOUT,
  output logic              DOUT_VLD,
  output logic              DOUT_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVLP
);
  typedef enum logic [2:0] {IDLE, HDR, READ, DRAIN, TRL} state_t;
  state_t      state;
  logic [4:0]  nsamp;
  logic [8:0]  cnt;
  logic [8:0]  last;
  logic        sent;
  logic        p1_vld;
  logic [3:0]  p1_chan;
  logic [11:0] evt_cnt;
  logic [11:0] trl_val;
  logic        hdr_go;
  logic        to_trl;
  logic        trl_go;
`ifdef RINGBUF_RD_CHKSUM_EN
  logic [11:0] chk;
  assign trl_val = chk;
`else
  assign trl_val = {3'b0, nsamp, 4'b0};
`endif
  assign last    = {nsamp, 4'b0} - 9'd1;
  assign RB_RDEN = (state == READ) & ~DOUT_AF;
  assign BUSY    = state != IDLE;
  // sent tracks whether the header/trailer of the current HDR/TRL state has been written out
  assign hdr_go  = ~DOUT_AF & (((state == IDLE) & START) | ((state == HDR) & ~sent));
  assign to_trl  = ((state == HDR) & sent & (nsamp == 5'd0)) | ((state == DRAIN) & ~p1_vld) | ((state == TRL) & ~sent);
  assign trl_go  = to_trl & ~DOUT_AF;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      nsamp     <= '0;
      cnt       <= '0;
      sent      <= 1'b0;
      p1_vld    <= 1'b0;
      p1_chan   <= '0;
      evt_cnt   <= '0;
      RB_ADDR   <= '0;
      DOUT      <= '0;
      DOUT_VLD  <= 1'b0;
      DOUT_LAST <= 1'b0;
      DONE      <= 1'b0;
      OVLP      <= 1'b0;
`ifdef RINGBUF_RD_CHKSUM_EN
      chk       <= '0;
`endif
    end else begin
      p1_vld    <= RB_RDEN;
      p1_chan   <= cnt[3:0];
      DOUT_VLD  <= p1_vld | hdr_go | trl_go;
      DOUT_LAST <= trl_go;
      DONE      <= trl_go;
      DOUT      <= hdr_go ? {4'hA, evt_cnt} : trl_go ? {4'hF, trl_val} : p1_vld ? {p1_chan, RB_DOUT} : DOUT;
      sent      <= ((state == IDLE) | to_trl) ? ~DOUT_AF : sent | hdr_go;
      if (trl_go) evt_cnt <= evt_cnt + 12'd1;
      if (START & (state != IDLE)) OVLP <= 1'b1;
`ifdef RINGBUF_RD_CHKSUM_EN
      if (p1_vld) chk <= chk ^ RB_DOUT;
      if ((state == IDLE) & START) chk <= '0;
`endif
      case (state)
        IDLE: if (START) begin
          state   <= HDR;
          nsamp   <= NSAMP;
          RB_ADDR <= START_ADDR;
          cnt     <= '0;
        end
        HDR:   if (sent) state <= (nsamp != 5'd0) ? READ : TRL;
        READ: if (RB_RDEN) begin
          RB_ADDR <= RB_ADDR + 1'b1;
          cnt     <= cnt + 9'd1;
          if (cnt == last) state <= DRAIN;
        end
        DRAIN: if (!p1_vld) state <= TRL;
        TRL:   if (sent) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ringbuf_reader.sv
// tb_ringbuf_reader: randomized checks of ringbuf_reader against a word-list reference model.
module tb_ringbuf_reader;
  localparam int AW = 11;
  logic          CLK = 0, RST = 1, START = 0, DOUT_AF = 0;
  logic [AW-1:0] START_ADDR = '0;
  logic [4:0]    NSAMP = '0;
  logic [AW-1:0] RB_ADDR;
  logic          RB_RDEN;
  logic [11:0]   RB_DOUT = '0;
  logic [15:0]   DOUT;
  logic          DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP;
  logic [11:0]   ram [2**AW];
  int            vectors = 0, errs = 0, cyc = 0, last_cnt = 0, done_cnt = 0, m_evt = 0;
  logic [15:0]   got_q[$], exp_q[$];
  logic [AW-1:0] addr_q[$], eaddr_q[$];
  int            cyc_q[$];

  ringbuf_reader #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .NSAMP(NSAMP),
    .RB_ADDR(RB_ADDR), .RB_RDEN(RB_RDEN), .RB_DOUT(RB_DOUT), .DOUT_AF(DOUT_AF),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_LAST(DOUT_LAST), .BUSY(BUSY), .DONE(DONE), .OVLP(OVLP)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RB_RDEN) RB_DOUT <= ram[RB_ADDR];
  end

  always @(negedge CLK) if (!RST) begin
    if (DOUT_VLD) begin
      got_q.push_back(DOUT);
      cyc_q.push_back(cyc);
    end
    if (RB_RDEN) addr_q.push_back(RB_ADDR);
    if (DOUT_LAST) last_cnt++;
    if (DONE) done_cnt++;
  end

  task automatic run_event(input logic [AW-1:0] a, input logic [4:0] ns, input int pct,
                           input int af_lo, input int af_hi, input int ovlp_at, input string nm);
    logic [11:0]   chk = '0;
    logic [11:0]   t;
    logic [AW-1:0] ra;
    int            k = 1;
    logic          seen = 0;
    exp_q.delete();
    eaddr_q.delete();
    exp_q.push_back({4'hA, 12'(m_evt)});
    for (int s = 0; s < int'(ns); s++)
      for (int c = 0; c < 16; c++) begin
        ra = AW'(int'(a) + 16 * s + c);
        eaddr_q.push_back(ra);
        exp_q.push_back({4'(c), ram[ra]});
        chk ^= ram[ra];
      end
`ifdef RINGBUF_RD_CHKSUM_EN
    t = chk;
`else
    t = 12'(16 * int'(ns));
`endif
    exp_q.push_back({4'hF, t});
    m_evt = (m_evt + 1) % 4096;
    @(posedge CLK); #1;
    START_ADDR = a; NSAMP = ns; START = 1; DOUT_AF = 0;
    got_q.delete(); addr_q.delete(); cyc_q.delete(); last_cnt = 0; done_cnt = 0;
    @(posedge CLK); #1;
    while (!seen && k < 3000) begin
      START = (k == ovlp_at);
      DOUT_AF = (k >= af_lo && k <= af_hi) || ($urandom_range(0, 99) < pct);
      @(negedge CLK);
      seen = DONE;
      @(posedge CLK); #1;
      k++;
    end
    START = 0; DOUT_AF = 0;
    @(negedge CLK);
    vectors++; if (!seen) begin errs++; $display("FAIL %s done_timeout got none required DONE", nm); end
    vectors++; if (BUSY !== 1'b0) begin errs++; $display("FAIL %s busy_after got %b required 0", nm, BUSY); end
    vectors++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL %s word_count got %0d required %0d", nm, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL %s word[%0d] got %h required %h", nm, i, got_q[i], exp_q[i]); end
    end
    vectors++; if (addr_q.size() !== eaddr_q.size()) begin errs++; $display("FAIL %s read_count got %0d required %0d", nm, addr_q.size(), eaddr_q.size()); end
    for (int i = 0; i < eaddr_q.size() && i < addr_q.size(); i++) begin
      vectors++;
      if (addr_q[i] !== eaddr_q[i]) begin errs++; $display("FAIL %s rb_addr[%0d] got %h required %h", nm, i, addr_q[i], eaddr_q[i]); end
    end
    vectors++; if (last_cnt !== 1 || done_cnt !== 1) begin errs++; $display("FAIL %s last_done got %0d/%0d required 1/1", nm, last_cnt, done_cnt); end
  endtask

  task automatic test_reset;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    vectors++; if ({RB_ADDR, RB_RDEN, DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP} !== '0) begin
      errs++; $display("FAIL reset_ctrl got %h required 0", {RB_ADDR, RB_RDEN, DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP});
    end
    vectors++; if (DOUT !== 16'h0) begin errs++; $display("FAIL reset_dout got %h required 0000", DOUT); end
    @(posedge CLK); #1 RST = 0;
    m_evt = 0;
  endtask

  task automatic test_basic;
    logic        ev, er, eb, el;
    logic [15:0] ew;
    @(posedge CLK); #1;
    START = 1; START_ADDR = 11'h010; NSAMP = 5'd1;
    @(posedge CLK); #1 START = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLK);
      ev = (k == 1) || (k >= 4 && k <= 20);
      er = k >= 2 && k <= 17;
      eb = k <= 20;
      el = k == 20;
`ifdef RINGBUF_RD_CHKSUM_EN
      ew = k == 1 ? {4'hA, 12'(m_evt)} : k == 20 ? 16'hF000 : {4'(k - 4), 12'(16 + k - 4)};
`else
      ew = k == 1 ? {4'hA, 12'(m_evt)} : k == 20 ? 16'hF010 : {4'(k - 4), 12'(16 + k - 4)};
`endif
      vectors++;
      if ({DOUT_VLD, RB_RDEN, BUSY, DOUT_LAST, DONE} !== {ev, er, eb, el, el}) begin
        errs++; $display("FAIL basic_ctrl cycle %0d got %b required %b", k, {DOUT_VLD, RB_RDEN, BUSY, DOUT_LAST, DONE}, {ev, er, eb, el, el});
      end
      if (ev) begin
        vectors++; if (DOUT !== ew) begin errs++; $display("FAIL basic_dout cycle %0d got %h required %h", k, DOUT, ew); end
      end
      if (er) begin
        vectors++; if (RB_ADDR !== AW'(16 + k - 2)) begin errs++; $display("FAIL basic_addr cycle %0d got %h required %h", k, RB_ADDR, AW'(16 + k - 2)); end
      end
    end
    m_evt++;
  endtask

  task automatic test_af;
    int bub;
    run_event(AW'($urandom), 5'd2, 0, 10, 12, 0, "af");
    vectors++;
    if (cyc_q.size() >= 34) begin
      bub = cyc_q[32] - cyc_q[1] + 1 - 32;
      if (bub !== 3) begin errs++; $display("FAIL af_bubbles got %0d required 3", bub); end
    end else begin
      errs++; $display("FAIL af_bubbles got %0d words required 34", cyc_q.size());
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 2**AW; i++) ram[i] = 12'($urandom);
    for (int e = 0; e < 6; e++)
      run_event(AW'($urandom), 5'($urandom_range(0, 31)), 30, 0, -1, 0, "random");
  endtask

  task automatic test_ovlp;
    vectors++; if (OVLP !== 1'b0) begin errs++; $display("FAIL ovlp_pre got %b required 0", OVLP); end
    run_event(AW'($urandom), 5'd3, 0, 0, -1, 5, "ovlp");
    vectors++; if (OVLP !== 1'b1) begin errs++; $display("FAIL ovlp_set got %b required 1", OVLP); end
    repeat (5) @(posedge CLK);
    #1;
    vectors++; if (OVLP !== 1'b1 || BUSY !== 1'b0) begin errs++; $display("FAIL ovlp_sticky got %b/%b required 1/0", OVLP, BUSY); end
  endtask

  task automatic test_rst_mid;
    @(posedge CLK); #1;
    START = 1; START_ADDR = AW'($urandom); NSAMP = 5'd4;
    @(posedge CLK); #1 START = 0;
    repeat (9) @(posedge CLK);
    #1 RST = 1;
    #1;
    vectors++; if ({RB_ADDR, RB_RDEN, DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP} !== '0) begin
      errs++; $display("FAIL rst_mid_ctrl got %h required 0", {RB_ADDR, RB_RDEN, DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP});
    end
    vectors++; if (DOUT !== 16'h0) begin errs++; $display("FAIL rst_mid_dout got %h required 0000", DOUT); end
    @(posedge CLK); #1 RST = 0;
    m_evt = 0;
    run_event(AW'($urandom), 5'd1, 0, 0, -1, 0, "rst_mid");
    vectors++; if (got_q.size() == 0 || got_q[0] !== 16'hA000) begin errs++; $display("FAIL rst_mid_hdr got %h required a000", got_q.size() ? got_q[0] : 16'hx); end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = 12'(i);
    test_reset;
    test_basic;
    run_event(11'h7F8, 5'd1, 0, 0, -1, 0, "wrap");
    run_event(AW'($urandom), 5'd0, 0, 0, -1, 0, "zero_a");
    run_event(AW'($urandom), 5'd0, 0, 0, -1, 0, "zero_b");
    test_af;
    test_random;
    test_ovlp;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
